igmp_rx_ctrl: RTL
=================

// Module: igmp_rx_ctrl
// PURPOSE
// - Sequencer in front of the receiving_igmp header parser. Accepts IGMP payload as a 32-bit word stream,
//   latches the first four words onto h1..h4, starts the parser, collects its valid/invalid verdict and
//   emits one membership event (query/report/leave) per good message through a valid/ready handshake.
// - Sits between the IP payload demux and the group-membership table.
// PARAMETERS
// - TIMEOUT  64  cycles to wait in WAIT for a parser verdict before declaring the message bad.
// - CNT_W    16  width of the statistics counters (IGMP_RX_STATS_EN only).
// PORTS
// - clk        in   1   single clock, rising edge.
// - rst        in   1   asynchronous, active-low reset.
// - in_data    in   32  payload word; word 0 = type/mrc/checksum.
// - in_valid   in   1   in_data valid.   in_last in 1: final word of message.
// - in_ready   out  1   block accepts a word this cycle.
// - h1..h4     out  32  latched header words to parser; stable from hdr_start until return to IDLE.
// - hdr_start  out  1   one-cycle pulse: h1..h4 are complete.
// - p_valid    in   1   parser verdict good.   p_invalid in 1: verdict bad.
// - p_type     in   8   parsed type field.     p_group in 32: parsed group address.
// - ev_valid   out  1   event pending.         ev_ready in 1: consumer takes event.
// - ev_kind    out  2   0 query, 1 report (v2 or v3), 2 leave, 3 other.
// - ev_group   out  32  group address of event.
// - busy       out  1   state != IDLE.
// BEHAVIOUR
// - Reset (rst=0): state IDLE; h1..h4, ev_group = 0; hdr_start, ev_valid, busy = 0; ev_kind = 0; in_ready = 0.
// - States IDLE, LOAD, DRAIN, PARSE, WAIT, EMIT. in_ready = 1 in IDLE/LOAD/DRAIN, else 0.
// - IDLE: accepted word -> h1, word cnt=1, go LOAD. If that word has in_last: runt, drop, stay IDLE.
// - LOAD: accepted words fill h2,h3,h4 in order. in_last before the 4th word: runt, drop, go IDLE.
//   4th word with in_last -> PARSE; 4th word without in_last -> DRAIN.
// - DRAIN: accept and discard words (IGMPv3 source list) until in_last accepted -> PARSE.
// - PARSE: hdr_start=1 for exactly one cycle -> WAIT; timer cleared.
// - WAIT: p_invalid (alone or together with p_valid) -> bad, go IDLE. p_valid alone -> latch kind and
//   group, go EMIT. Timer reaches TIMEOUT-1 with no verdict -> bad, go IDLE. Verdicts outside WAIT ignored.
// - Kind decode: 0x11 ->0; 0x16 or 0x22 ->1; 0x17 ->2; anything else ->3.
// - EMIT: ev_valid held high, ev_kind/ev_group stable, until ev_valid&ev_ready -> IDLE next cycle.
//   No combinational path from ev_ready to ev_valid.
// - Latency: last accepted word -> hdr_start next cycle; p_valid -> ev_valid next cycle.
// - Back-to-back: new message accepted the cycle after EMIT handshake (IDLE re-entry); no overlap.
// - in_valid low mid-message: hold state, no timeout in LOAD/DRAIN.
// - Reset mid-operation: immediate return to reset values; partial message lost, no event.
// CONFIGURATION
// - IGMP_RX_STATS_EN defined: adds outputs cnt_good, cnt_bad, cnt_runt (CNT_W each, reset 0):
//   +1 on EMIT handshake / bad verdict or timeout / runt drop respectively; saturate at all-ones.
// - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
// - igmp_pkg: IGMP type constants (IGMP_QUERY 8'h11, IGMP_V2_REPORT 8'h16, IGMP_V3_REPORT 8'h22,
//   IGMP_LEAVE 8'h17), ev_kind encodings, state encoding.
// - One sub-module: igmp_rx_stats (saturating counter set), instantiated only under IGMP_RX_STATS_EN.
// - Parser itself is not instantiated; it connects at the level above.
// TESTING
// - Reset: rst=0 mid-LOAD after 2 words -> all outputs 0, next message parsed from word 0.
// - Good v2 report, 4 words (word0=32'h1600_0000.., last on 4th), p_valid next cycle with p_type 8'h16,
//   p_group 32'hE000_00FB -> hdr_start 1 cycle, ev_valid, ev_kind=1, ev_group=32'hE000_00FB; hold
//   ev_ready=0 5 cycles -> event stable; handshake -> IDLE, in_ready=1.
// - v3 report 7 words -> 3 words drained, hdr_start after 7th word, ev_kind=1.
// - Runt: 3 words with in_last on 3rd -> no hdr_start, cnt_runt=1 (STATS_EN).
// - Parser silent -> after TIMEOUT=64 cycles in WAIT return IDLE, no event, cnt_bad=1;
//   p_valid and p_invalid same cycle -> bad, no event.
// - Back-to-back: query (0x11) then leave (0x17) with in_valid held high -> two events kind 0 then 2,
//   cnt_good=2; counters saturate at 16'hFFFF under forced overflow.

Source files
------------

// File: rtl/igmp_pkg.sv
// -----------------------------------------------------------------------------
// igmp_pkg
// Shared definitions for the IGMP receive sequencer:
//   - IGMP message type codes as they appear in the first byte of word 0
//   - membership event kinds reported on ev_kind
//   - sequencer state encoding
//   - decode_kind(): maps a parsed type byte onto an event kind
// -----------------------------------------------------------------------------
package igmp_pkg;

  localparam logic [7:0] IGMP_QUERY     = 8'h11;
  localparam logic [7:0] IGMP_V2_REPORT = 8'h16;
  localparam logic [7:0] IGMP_V3_REPORT = 8'h22;
  localparam logic [7:0] IGMP_LEAVE     = 8'h17;

  typedef enum logic [1:0] {
    EV_QUERY  = 2'd0,
    EV_REPORT = 2'd1,
    EV_LEAVE  = 2'd2,
    EV_OTHER  = 2'd3
  } ev_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PARSE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_EMIT  = 3'd5
  } state_t;

  // v2 and v3 membership reports collapse onto the same event kind.
  function automatic ev_kind_t decode_kind(input logic [7:0] t);
    case (t)
      IGMP_QUERY:                     return EV_QUERY;
      IGMP_V2_REPORT, IGMP_V3_REPORT: return EV_REPORT;
      IGMP_LEAVE:                     return EV_LEAVE;
      default:                        return EV_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/igmp_rx_ctrl_if.sv
// -----------------------------------------------------------------------------
// igmp_rx_ctrl_if
// Bundles the two handshake paths of the IGMP receive sequencer:
//   in_data/in_valid/in_last/in_ready : payload word stream into the sequencer
//   ev_valid/ev_ready/ev_kind/ev_group: membership events out of the sequencer
// Modports:
//   slave  - the sequencer (consumes words, produces events)
//   master - the surroundings (IP demux feeding words, membership table
//            taking events)
// -----------------------------------------------------------------------------
interface igmp_rx_ctrl_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        ev_valid;
  logic        ev_ready;
  logic [1:0]  ev_kind;
  logic [31:0] ev_group;

  modport master (
    output in_data, in_valid, in_last, ev_ready,
    input  in_ready, ev_valid, ev_kind, ev_group
  );

  modport slave (
    input  in_data, in_valid, in_last, ev_ready,
    output in_ready, ev_valid, ev_kind, ev_group
  );
endinterface

// File: rtl/igmp_rx_stats.sv
// -----------------------------------------------------------------------------
// igmp_rx_stats
// Three saturating event counters (good messages, bad verdicts/timeouts,
// runt drops). Each counter sticks at all-ones instead of wrapping.
// Ports:
//   clk, rst (async, active-low)
//   inc_good, inc_bad, inc_runt : one-cycle increment strobes
//   cnt_good, cnt_bad, cnt_runt : CNT_W-bit counter values
// -----------------------------------------------------------------------------
module igmp_rx_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_good,
  input  logic             inc_bad,
  input  logic             inc_runt,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad,
  output logic [CNT_W-1:0] cnt_runt
);

  logic [2:0]       inc;
  logic [CNT_W-1:0] cnt_arr [3];

  assign inc = {inc_runt, inc_bad, inc_good};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
        end else if (inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt_arr[gi] = cnt_reg;
    end
  endgenerate

  assign cnt_good = cnt_arr[0];
  assign cnt_bad  = cnt_arr[1];
  assign cnt_runt = cnt_arr[2];

endmodule

// File: rtl/igmp_rx_ctrl.sv
// -----------------------------------------------------------------------------
// igmp_rx_ctrl
// Sequencer in front of the IGMP header parser. Collects the first four
// payload words onto h1..h4, discards any further words (v3 source lists),
// pulses hdr_start, waits for the parser verdict and emits one membership
// event per good message.
// Ports:
//   clk, rst           single clock; asynchronous active-low reset
//   bus (slave)        word stream in (in_*), membership events out (ev_*)
//   h1..h4             latched header words, stable from hdr_start to IDLE
//   hdr_start          one-cycle pulse, header words complete
//   p_valid/p_invalid  parser verdict (only sampled while waiting for it)
//   p_type, p_group    parsed type byte and group address
//   busy               sequencer is not idle
//   cnt_good/bad/runt  statistics (only when IGMP_RX_STATS_EN is defined)
// Parameters: TIMEOUT (verdict wait, cycles), CNT_W (statistics width)
// Build option: IGMP_RX_STATS_EN adds the saturating statistics counters.
// -----------------------------------------------------------------------------
module igmp_rx_ctrl
  import igmp_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  igmp_rx_ctrl_if.slave    bus,
  output logic [31:0]      h1,
  output logic [31:0]      h2,
  output logic [31:0]      h3,
  output logic [31:0]      h4,
  output logic             hdr_start,
  input  logic             p_valid,
  input  logic             p_invalid,
  input  logic [7:0]       p_type,
  input  logic [31:0]      p_group,
  output logic             busy
`ifdef IGMP_RX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad,
  output logic [CNT_W-1:0] cnt_runt
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state_reg, state_next;
  logic [1:0]    cnt_reg, cnt_next;
  logic [31:0]   h1_reg, h1_next, h2_reg, h2_next;
  logic [31:0]   h3_reg, h3_next, h4_reg, h4_next;
  logic [TW-1:0] timer_reg, timer_next;
  ev_kind_t      kind_reg, kind_next;
  logic [31:0]   group_reg, group_next;
  logic          in_ready_reg;
  logic          accept;
  logic          good_evt, bad_evt, runt_evt;

  // in_ready is registered so that it reads 0 while reset is held even
  // though the reset state (IDLE) is a word-accepting state.
  assign accept = bus.in_valid && in_ready_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    h1_next    = h1_reg;
    h2_next    = h2_reg;
    h3_next    = h3_reg;
    h4_next    = h4_reg;
    timer_next = timer_reg;
    kind_next  = kind_reg;
    group_next = group_reg;
    good_evt   = 1'b0;
    bad_evt    = 1'b0;
    runt_evt   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (bus.in_last) begin
            runt_evt = 1'b1;
          end else begin
            h1_next    = bus.in_data;
            cnt_next   = 2'd1;
            state_next = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          case (cnt_reg)
            2'd1:    h2_next = bus.in_data;
            2'd2:    h3_next = bus.in_data;
            default: h4_next = bus.in_data;
          endcase
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            state_next = bus.in_last ? ST_PARSE : ST_DRAIN;
          end else if (bus.in_last) begin
            runt_evt   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        if (accept && bus.in_last) begin
          state_next = ST_PARSE;
        end
      end

      ST_PARSE: begin
        timer_next = '0;
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        // An invalid verdict wins even if valid is raised in the same cycle.
        if (p_invalid) begin
          bad_evt    = 1'b1;
          state_next = ST_IDLE;
        end else if (p_valid) begin
          kind_next  = decode_kind(p_type);
          group_next = p_group;
          state_next = ST_EMIT;
        end else if (timer_reg == TW'(TIMEOUT - 1)) begin
          bad_evt    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      ST_EMIT: begin
        if (bus.ev_ready) begin
          good_evt   = 1'b1;
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      h1_reg       <= '0;
      h2_reg       <= '0;
      h3_reg       <= '0;
      h4_reg       <= '0;
      timer_reg    <= '0;
      kind_reg     <= EV_QUERY;
      group_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      h1_reg       <= h1_next;
      h2_reg       <= h2_next;
      h3_reg       <= h3_next;
      h4_reg       <= h4_next;
      timer_reg    <= timer_next;
      kind_reg     <= kind_next;
      group_reg    <= group_next;
      in_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_LOAD) ||
                      (state_next == ST_DRAIN);
    end
  end

  // All handshake outputs come straight from registers: ev_ready never
  // reaches ev_valid combinationally.
  assign h1           = h1_reg;
  assign h2           = h2_reg;
  assign h3           = h3_reg;
  assign h4           = h4_reg;
  assign hdr_start    = (state_reg == ST_PARSE);
  assign busy         = (state_reg != ST_IDLE);
  assign bus.in_ready = in_ready_reg;
  assign bus.ev_valid = (state_reg == ST_EMIT);
  assign bus.ev_kind  = kind_reg;
  assign bus.ev_group = group_reg;

`ifdef IGMP_RX_STATS_EN
  igmp_rx_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk      (clk),
    .rst      (rst),
    .inc_good (good_evt),
    .inc_bad  (bad_evt),
    .inc_runt (runt_evt),
    .cnt_good (cnt_good),
    .cnt_bad  (cnt_bad),
    .cnt_runt (cnt_runt)
  );
`else
  logic [CNT_W+2:0] unused_stats;
  assign unused_stats = {good_evt, bad_evt, runt_evt, {CNT_W{1'b0}}};
`endif

endmodule
